// File: rtl/serial_rx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_rx_arbiter
//
// Shares one MSB-first serial-to-parallel capture engine between N_CH serial
// requesters. A channel is picked round-robin from the asserted requests. It
// then holds the grant for one whole DATA_W-bit frame. Each completed word is
// presented together with the index of its source channel. If a granted
// channel stalls for TIMEOUT consecutive cycles inside a frame, the frame is
// aborted so that the channel cannot lock out the others.
//
// Ports
//   clk            in   1       clock, rising edge
//   rst_n          in   1       asynchronous active-low reset
//   req            in   N_CH    per-channel request (level)
//   ser_data       in   N_CH    per-channel serial bit
//   ser_valid      in   N_CH    per-channel bit-valid qualifier
//   gnt            out  N_CH    one-hot grant, registered
//   busy           out  1       frame in progress
//   dout_parallel  out  DATA_W  captured word, first bit in MSB
//   dout_valid     out  1       one-cycle pulse, dout_parallel/dout_ch valid
//   dout_ch        out  CH_W    source channel of dout_parallel
//   abort          out  1       one-cycle pulse, frame aborted on timeout
//   abort_ch       out  CH_W    channel of the aborted frame
// -----------------------------------------------------------------------------
module serial_rx_arbiter #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH-1:0]   ser_data,
    input  logic [N_CH-1:0]   ser_valid,
    output logic [N_CH-1:0]   gnt,
    output logic              busy,
    output logic [DATA_W-1:0] dout_parallel,
    output logic              dout_valid,
    output logic [CH_W-1:0]   dout_ch,
    output logic              abort,
    output logic [CH_W-1:0]   abort_ch
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam int IC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_W - 1);
    localparam logic [IC_W-1:0] IDLE_MAX  = IC_W'(TIMEOUT);
    // idle_cnt value that, with one more stall cycle, reaches TIMEOUT
    localparam logic [IC_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? IC_W'(TIMEOUT - 1) : '0;
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(N_CH - 1);

    logic [0:0]        state_reg;
    logic [CH_W-1:0]   rr_ptr_reg;
    logic [CH_W-1:0]   cur_ch_reg;
    logic [BC_W-1:0]   bit_cnt_reg;
    logic [IC_W-1:0]   idle_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [N_CH-1:0]   gnt_reg;
    logic [DATA_W-1:0] dout_parallel_reg;
    logic              dout_valid_reg;
    logic [CH_W-1:0]   dout_ch_reg;
    logic              abort_reg;
    logic [CH_W-1:0]   abort_ch_reg;

    // ------------------------------------------------------------------
    // Round-robin pick: candidate gi is the channel gi places after the
    // pointer (wrapping), so the first hit in candidate order wins.
    // ------------------------------------------------------------------
    logic [CH_W-1:0] cand_idx [N_CH];
    logic [N_CH-1:0] cand_hit;
    logic            pick_found;
    logic [CH_W-1:0] pick_ch;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
            assign cand_idx[gi] = CH_W'((int'(rr_ptr_reg) + gi) % N_CH);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!pick_found && cand_hit[k]) begin
                pick_found = 1'b1;
                pick_ch    = cand_idx[k];
            end
        end
    end

    // Granted channel's serial inputs; all other lanes are ignored.
    logic            cur_valid;
    logic            cur_data;
    logic [CH_W-1:0] next_ptr;

    assign cur_valid = ser_valid[cur_ch_reg];
    assign cur_data  = ser_data[cur_ch_reg];
    assign next_ptr  = (cur_ch_reg == CH_LAST) ? '0 : cur_ch_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            rr_ptr_reg        <= '0;
            cur_ch_reg        <= '0;
            bit_cnt_reg       <= '0;
            idle_cnt_reg      <= '0;
            shift_reg         <= '0;
            gnt_reg           <= '0;
            dout_parallel_reg <= '0;
            dout_valid_reg    <= 1'b0;
            dout_ch_reg       <= '0;
            abort_reg         <= 1'b0;
            abort_ch_reg      <= '0;
        end else begin
            dout_valid_reg <= 1'b0;
            abort_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        gnt_reg      <= N_CH'(1) << pick_ch;
                        cur_ch_reg   <= pick_ch;
                        state_reg    <= SHIFT;
                        bit_cnt_reg  <= '0;
                        idle_cnt_reg <= '0;
                        shift_reg    <= '0;
                    end
                end
                SHIFT: begin
                    if (cur_valid) begin
                        shift_reg    <= {shift_reg[DATA_W-2:0], cur_data};
                        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        idle_cnt_reg <= '0;
                        if (bit_cnt_reg == LAST_BIT) begin
                            // Present the word including the bit arriving now.
                            dout_parallel_reg <= {shift_reg[DATA_W-2:0], cur_data};
                            dout_ch_reg       <= cur_ch_reg;
                            dout_valid_reg    <= 1'b1;
                            gnt_reg           <= '0;
                            state_reg         <= IDLE;
                            rr_ptr_reg        <= next_ptr;
                        end
                    end else if ((TIMEOUT != 0) && (idle_cnt_reg == IDLE_LAST)) begin
                        // Stall limit hit: drop partial data and release the engine.
                        abort_reg    <= 1'b1;
                        abort_ch_reg <= cur_ch_reg;
                        gnt_reg      <= '0;
                        state_reg    <= IDLE;
                        rr_ptr_reg   <= next_ptr;
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end else if (idle_cnt_reg != IDLE_MAX) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt           = gnt_reg;
    assign busy          = (state_reg == SHIFT);
    assign dout_parallel = dout_parallel_reg;
    assign dout_valid    = dout_valid_reg;
    assign dout_ch       = dout_ch_reg;
    assign abort         = abort_reg;
    assign abort_ch      = abort_ch_reg;

endmodule

// File: tb/tb_serial_rx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_rx_arbiter
//
// Directed bench for serial_rx_arbiter (N_CH=4, DATA_W=8, TIMEOUT=16).
// Inputs are driven 1 ns after a rising edge; outputs are sampled at the same
// point, so each sample reflects the edge just taken.
// Frame time is counted in rising edges from the grant edge to the
// dout_valid edge, both included: DATA_W+1 plus one per stall cycle.
// -----------------------------------------------------------------------------
module tb_serial_rx_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ser_data;
    logic [3:0] ser_valid;
    logic [3:0] gnt;
    logic       busy;
    logic [7:0] dout_parallel;
    logic       dout_valid;
    logic [1:0] dout_ch;
    logic       abort;
    logic [1:0] abort_ch;

    int checks = 0;
    int errors = 0;

    serial_rx_arbiter #(
        .N_CH    (4),
        .DATA_W  (8),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .ser_data      (ser_data),
        .ser_valid     (ser_valid),
        .gnt           (gnt),
        .busy          (busy),
        .dout_parallel (dout_parallel),
        .dout_valid    (dout_valid),
        .dout_ch       (dout_ch),
        .abort         (abort),
        .abort_ch      (abort_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the grant, streams one frame on channel ch with noise on the
    // other lanes, optionally stalling stall_n cycles after bit stall_pos.
    task automatic run_frame(input int ch, input logic [7:0] word, input int stall_pos,
                             input int stall_n, input logic [3:0] exp_gnt);
        int waits;
        int cyc;
        int early;
        waits = 0;
        early = 0;
        do begin
            tick();
            waits++;
        end while (gnt == 4'b0000 && waits < 20);
        check("gnt_latency", waits, 1);
        check("gnt_onehot", 32'(gnt), 32'(exp_gnt));
        check("busy_in_frame", 32'(busy), 1);
        cyc = 1;
        for (int i = 0; i < 8; i++) begin
            ser_valid     = 4'($urandom);
            ser_data      = 4'($urandom);
            ser_valid[ch] = 1'b1;
            ser_data[ch]  = word[7-i];
            tick();
            cyc++;
            if (i < 7 && dout_valid) early++;
            if (i + 1 == stall_pos) begin
                for (int s = 0; s < stall_n; s++) begin
                    ser_valid     = 4'($urandom);
                    ser_data      = 4'($urandom);
                    ser_valid[ch] = 1'b0;
                    tick();
                    cyc++;
                    if (dout_valid) early++;
                end
            end
        end
        check("no_early_dout_valid", early, 0);
        check("dout_valid", 32'(dout_valid), 1);
        check("dout_parallel", 32'(dout_parallel), 32'(word));
        check("dout_ch", 32'(dout_ch), ch);
        check("frame_cycles", cyc, 9 + stall_n);
        check("gnt_drop", 32'(gnt), 0);
        ser_valid = 4'b0000;
        ser_data  = 4'b0000;
        $display("frame ch=%0d dout=%h dout_ch=%0d cycles=%0d", ch, dout_parallel, dout_ch, cyc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int hits;
        rst_n     = 1'b0;
        req       = 4'b0000;
        ser_data  = 4'b0000;
        ser_valid = 4'b0000;
        tick();
        tick();
        check("reset_outputs",
              {21'd0, gnt, busy, dout_valid, dout_ch, abort, abort_ch}, 0);
        check("reset_dout", 32'(dout_parallel), 0);
        rst_n = 1'b1;
        tick();

        // 1: single requester ch2, word A5
        req = 4'b0100;
        run_frame(2, 8'hA5, 0, 0, 4'b0100);
        req = 4'b0000;
        tick();

        // 2: all requesting after reset, order 0,1,2,3,0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        run_frame(0, 8'h11, 0, 0, 4'b0001);
        run_frame(1, 8'h22, 0, 0, 4'b0010);
        run_frame(2, 8'h33, 0, 0, 4'b0100);
        run_frame(3, 8'h44, 0, 0, 4'b1000);
        run_frame(0, 8'h55, 0, 0, 4'b0001);

        // 3: ch1 frame 3C with 3 stall cycles after bit 4
        req = 4'b0010;
        run_frame(1, 8'h3C, 4, 3, 4'b0010);

        // 6: ch2 frame FF while other lanes toggle
        req = 4'b0100;
        run_frame(2, 8'hFF, 0, 0, 4'b0100);

        // 4: ch0 sends 5 bits then stalls 16 cycles; ch3 is waiting
        req = 4'b0001;
        tick();
        check("abort_gnt", 32'(gnt), 32'(4'b0001));
        for (int i = 0; i < 5; i++) begin
            ser_valid = 4'b0001;
            ser_data  = {3'b000, i[0]};
            tick();
        end
        ser_valid = 4'b0000;
        req       = 4'b1001;
        hits      = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (abort || dout_valid || gnt != 4'b0001) hits++;
        end
        check("no_early_abort", hits, 0);
        tick();
        check("abort_pulse", 32'(abort), 1);
        check("abort_ch", 32'(abort_ch), 0);
        check("abort_no_dout", 32'(dout_valid), 0);
        check("abort_gnt_drop", 32'(gnt), 0);
        $display("abort ch=%0d", abort_ch);
        tick();
        check("abort_one_cycle", 32'(abort), 0);
        check("gnt_after_abort", 32'(gnt), 32'(4'b1000));

        // 5: reset in the middle of the ch3 frame
        for (int i = 0; i < 3; i++) begin
            ser_valid = 4'b1000;
            ser_data  = 4'b1000;
            tick();
        end
        ser_valid = 4'b0000;
        rst_n     = 1'b0;
        #1;
        check("midreset_outputs",
              {21'd0, gnt, busy, dout_valid, dout_ch, abort, abort_ch}, 0);
        check("midreset_dout", 32'(dout_parallel), 0);
        tick();
        tick();
        req   = 4'b1001;
        rst_n = 1'b1;
        $display("reset released req=%b", req);
        run_frame(0, 8'h5A, 0, 0, 4'b0001);
        req = 4'b0000;
        tick();
        check("idle_after_all", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
